// File: rtl/seg7_scan_decoder.sv
// Rebuilds the 16-bit hex value shown on a 4-digit, active-low, multiplexed seven-segment bus.
// A digit is captured STABLE_CYCLES edges after it first appears; there is no backpressure, and the frame_valid/timeout pulses are not held.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  a_to_g,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {HUNT, HOLD} state_t;

  state_t        state;
  logic [10:0]   samp_q;
  logic [7:0]    stab_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    cap_an;
  logic [3:0]    mask;
  logic [3:0]    err_slot;
  logic [15:0]   slot;

  logic          samp_legal;
  logic          same;
  logic          capture;
  logic          to_expire;
  logic [1:0]    cap_idx;
  logic [4:0]    glyph;
  logic [15:0]   slot_nx;
  logic [3:0]    err_nx;
  logic [3:0]    mask_nx;

  // Returns {illegal, nibble}; an unknown pattern decodes to nibble 0 with the flag set.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b1100000: decode = 5'h0B;
      7'b0110001: decode = 5'h0C;
      7'b1000010: decode = 5'h0D;
      7'b0110000: decode = 5'h0E;
      7'b0111000: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    samp_legal = an inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    same       = ({an, a_to_g} == samp_q);
    capture    = (state == HUNT) && (stab_cnt == 8'(STABLE_CYCLES - 1));
    to_expire  = (to_cnt == TW'(TIMEOUT_CYCLES - 2));
    case (samp_q[10:7])
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
    glyph   = decode(samp_q[6:0]);
    slot_nx = slot;
    slot_nx[{cap_idx, 2'b00} +: 4] = glyph[3:0];
    err_nx  = err_slot;
    err_nx[cap_idx] = glyph[4];
    mask_nx = mask;
    mask_nx[cap_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      samp_q      <= '0;
      stab_cnt    <= '0;
      to_cnt      <= '0;
      cap_an      <= '0;
      mask        <= '0;
      err_slot    <= '0;
      slot        <= '0;
      value       <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      samp_q      <= {an, a_to_g};
      frame_valid <= 1'b0;
      timeout     <= 1'b0;

      // Saturate so a digit held for a long time can never re-hit the capture count.
      if (same && samp_legal)
        stab_cnt <= (stab_cnt == 8'hFF) ? stab_cnt : stab_cnt + 8'd1;
      else
        stab_cnt <= '0;

      if (capture) begin
        slot     <= slot_nx;
        err_slot <= err_nx;
        cap_an   <= samp_q[10:7];
        to_cnt   <= '0;
        state    <= HOLD;
        if (mask_nx == 4'hF) begin
          value       <= slot_nx;
          digit_err   <= err_nx;
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= mask_nx;
        end
      end else begin
        if (state == HOLD && an != cap_an)
          state <= HUNT;
        if (to_expire) begin
          timeout <= 1'b1;
          mask    <= '0;
          state   <= HUNT;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: a run-length/history model is checked every cycle, alongside directed scans with hand-computed values.
module tb_seg7_scan_decoder;

  localparam int STB = 4;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fv_count = 0, fv_cyc = 0;
  int to_count = 0, to_cyc = 0;
  int last_ap = 0;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seg7_scan_decoder #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .a_to_g(a_to_g),
    .value(value), .digit_err(digit_err),
    .frame_valid(frame_valid), .timeout(timeout));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc = 0;
    else        cyc++;

  // Model state: run length of the current sample, per-digit slots, idle edges since last capture.
  logic [10:0] run_s;
  int          run_len;
  bit          hunt;
  logic [3:0]  m_cap_an;
  int          since;
  logic [3:0]  m_mask;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_err;
  logic [15:0] exp_value;
  logic [3:0]  exp_err;
  logic        exp_fv, exp_to;

  function automatic bit an_ok(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [10:0] s;
    int          d;
    logic [3:0]  nib;
    bit          err;
    if (!rst_n) begin
      run_s = '0; run_len = 0; hunt = 1; m_cap_an = '0; since = 0; m_mask = '0;
      for (int i = 0; i < 4; i++) m_slot[i] = '0;
      m_err = '0; exp_value = '0; exp_err = '0; exp_fv = 0; exp_to = 0;
    end else begin
      s = {an, a_to_g};
      exp_fv = 0;
      exp_to = 0;
      if (hunt && run_len == STB) begin
        d = 0;
        for (int i = 0; i < 4; i++) if (!run_s[7+i]) d = i;
        err = 1; nib = '0;
        for (int g = 0; g < 16; g++)
          if (glyph_tab[g] == run_s[6:0]) begin err = 0; nib = 4'(g); end
        m_slot[d] = nib; m_err[d] = err; m_mask[d] = 1'b1;
        hunt = 0; m_cap_an = run_s[10:7]; since = 0;
        if (m_mask == 4'hF) begin
          exp_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
          exp_err = m_err; exp_fv = 1; m_mask = '0;
        end
      end else begin
        if (s[10:7] != m_cap_an) hunt = 1;
        since++;
        if (since == TMO - 1) begin
          exp_to = 1; m_mask = '0; hunt = 1; since = 0;
        end
      end
      if (an_ok(s[10:7]) && s == run_s) run_len++;
      else begin
        run_s = s;
        run_len = an_ok(s[10:7]) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({value, digit_err, frame_valid, timeout} !== {exp_value, exp_err, exp_fv, exp_to}) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t: got value=%h err=%b fv=%b to=%b, want value=%h err=%b fv=%b to=%b",
               $time, value, digit_err, frame_valid, timeout, exp_value, exp_err, exp_fv, exp_to);
    end
    if (rst_n === 1'b1) begin
      if (frame_valid) begin fv_count++; fv_cyc = cyc; end
      if (timeout)     begin to_count++; to_cyc = cyc; end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] seg, input int n);
    an = a;
    a_to_g = seg;
    last_ap = cyc + 1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic dig(input int pos, input int g, input int n);
    logic [3:0] a;
    a = ~(4'b0001 << pos);
    hold(a, glyph_tab[g], n);
  endtask

  task automatic idle(input int n);
    hold(4'b1111, 7'h7F, n);
  endtask

  task automatic wait_to(input int t0);
    int k;
    k = 0;
    while (to_count == t0 && k < 400) begin idle(1); k++; end
    if (to_count == t0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_timeout: got no timeout pulse, want one within 400 cycles");
    end
  endtask

  int f0, t0, ap2;

  initial begin
    rst_n = 1'b0; an = 4'hF; a_to_g = 7'h7F;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_value", value, 16'h0);
    chk("reset_err", digit_err, 4'h0);
    chk("reset_fv", frame_valid, 1'b0);
    chk("reset_to", timeout, 1'b0);
    rst_n = 1'b1;

    // Digits held too briefly: nothing captured, then the idle timeout fires.
    dig(3, 1, 3); dig(2, 2, 3); dig(1, 3, 3); dig(0, 4, 3);
    wait_to(0);
    chk("short_to_cycle", to_cyc, 199);
    chk("short_no_frame", fv_count, 0);
    chk("short_value", value, 16'h0);

    f0 = fv_count;
    dig(3, 1, 10); dig(2, 2, 10); dig(1, 3, 10); dig(0, 4, 10);
    chk("clean_latency", fv_cyc - last_ap, 4);
    idle(2);
    chk("clean_value", value, 16'h1234);
    chk("clean_err", digit_err, 4'b0000);
    chk("clean_frames", fv_count - f0, 1);

    f0 = fv_count;
    dig(3, 10, 10); dig(2, 11, 10); hold(4'b1101, 7'h7F, 10); dig(0, 13, 10);
    idle(2);
    chk("blank_value", value, 16'hAB0D);
    chk("blank_err", digit_err, 4'b0010);
    chk("blank_frames", fv_count - f0, 1);

    f0 = fv_count;
    dig(3, 15, 10);
    hold(4'b1100, glyph_tab[15], 2);
    dig(2, 0, 6);
    hold(4'b1011, glyph_tab[8], 1);
    dig(2, 0, 3);
    hold(4'b1100, glyph_tab[0], 2);
    dig(1, 0, 10); dig(0, 14, 10);
    idle(2);
    chk("glitch_value", value, 16'hF00E);
    chk("glitch_err", digit_err, 4'b0000);
    chk("glitch_frames", fv_count - f0, 1);

    f0 = fv_count;
    dig(3, 1, 10); dig(2, 2, 10); dig(1, 3, 10);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset_value", value, 16'h0);
    rst_n = 1'b1;
    dig(3, 9, 10); dig(2, 8, 10); dig(1, 7, 10); dig(0, 6, 10);
    idle(2);
    chk("rescan_frames", fv_count - f0, 1);
    chk("rescan_value", value, 16'h9876);

    f0 = fv_count; t0 = to_count;
    dig(3, 5, 10); dig(2, 6, 10);
    ap2 = last_ap;
    wait_to(t0);
    chk("partial_to_cycle", to_cyc - ap2, 4 + 199);
    chk("partial_no_frame", fv_count - f0, 0);
    chk("partial_value", value, 16'h9876);
    dig(1, 3, 10); dig(0, 4, 10);
    chk("half_no_frame", fv_count - f0, 0);
    dig(3, 7, 10); dig(2, 8, 10);
    idle(2);
    chk("after_to_frames", fv_count - f0, 1);
    chk("after_to_value", value, 16'h7834);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
